// File: rtl/quad_encoder_speed.sv
// Multi-channel x4 quadrature decoder with a fixed-window signed speed measurement.
// Define QENC_POSITION_EN to add a free-running 32-bit absolute position output per channel.
module quad_encoder_speed #(
  parameter int N_CH        = 2,
  parameter int CNT_W       = 16,
  parameter int WINDOW      = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         enc_a,
  input  logic [N_CH-1:0]         enc_b,
  input  logic                    clear,
  output logic [N_CH*CNT_W-1:0]   speed,
  output logic [N_CH-1:0]         dir,
  output logic [N_CH-1:0]         err,
  output logic [N_CH-1:0]         ovf,
  output logic                    valid
`ifdef QENC_POSITION_EN
  ,
  output logic [N_CH*32-1:0]      pos
`endif
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic signed [CNT_W-1:0] ACC_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] ACC_MIN = {1'b1, {(CNT_W-1){1'b0}}};

  logic [WIN_W-1:0] win_cnt;
  logic             win_end;

  assign win_end = (win_cnt == WIN_LAST);

  // Shared window timer; clear beats a coincident window end, so no publish then.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt <= '0;
      valid   <= 1'b0;
    end else begin
      valid <= win_end & ~clear;
      if (clear || win_end) begin
        win_cnt <= '0;
      end else begin
        win_cnt <= win_cnt + WIN_W'(1);
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0]   sync_a;
    logic [SYNC_STAGES-1:0]   sync_b;
    logic [1:0]               prev_ab;
    logic [1:0]               cur_ab;
    logic                     inc;
    logic                     dec;
    logic                     bad;
    logic signed [CNT_W-1:0]  acc;
    logic signed [CNT_W-1:0]  acc_nxt;
    logic signed [CNT_W-1:0]  speed_q;
    logic                     win_err;
    logic                     win_ovf;
    logic                     err_nxt;
    logic                     ovf_nxt;
    logic                     dir_q;
    logic                     err_q;
    logic                     ovf_q;

    assign cur_ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

    always_comb begin
      inc = 1'b0;
      dec = 1'b0;
      bad = 1'b0;
      case ({prev_ab, cur_ab})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: inc = 1'b1;
        4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: dec = 1'b1;
        4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: bad = 1'b1;
        default: ;
      endcase
    end

    // Saturating window accumulator: a step that would cross a rail is dropped and flagged.
    always_comb begin
      acc_nxt = acc;
      ovf_nxt = win_ovf;
      err_nxt = win_err | bad;
      if (inc) begin
        if (acc == ACC_MAX) ovf_nxt = 1'b1;
        else                acc_nxt = acc + CNT_W'(1);
      end else if (dec) begin
        if (acc == ACC_MIN) ovf_nxt = 1'b1;
        else                acc_nxt = acc - CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        sync_a  <= '0;
        sync_b  <= '0;
        prev_ab <= 2'b00;
        acc     <= '0;
        win_err <= 1'b0;
        win_ovf <= 1'b0;
        speed_q <= '0;
        dir_q   <= 1'b0;
        err_q   <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        sync_a  <= {sync_a[SYNC_STAGES-2:0], enc_a[i]};
        sync_b  <= {sync_b[SYNC_STAGES-2:0], enc_b[i]};
        prev_ab <= cur_ab;
        if (inc)      dir_q <= 1'b1;
        else if (dec) dir_q <= 1'b0;
        if (clear) begin
          acc     <= '0;
          win_err <= 1'b0;
          win_ovf <= 1'b0;
        end else if (win_end) begin
          speed_q <= acc_nxt;
          err_q   <= err_nxt;
          ovf_q   <= ovf_nxt;
          acc     <= '0;
          win_err <= 1'b0;
          win_ovf <= 1'b0;
        end else begin
          acc     <= acc_nxt;
          win_err <= err_nxt;
          win_ovf <= ovf_nxt;
        end
      end
    end

    assign speed[i*CNT_W +: CNT_W] = speed_q;
    assign dir[i] = dir_q;
    assign err[i] = err_q;
    assign ovf[i] = ovf_q;

`ifdef QENC_POSITION_EN
    // Position ignores clear and window boundaries and wraps freely.
    logic [31:0] pos_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        pos_q <= '0;
      end else if (inc) begin
        pos_q <= pos_q + 32'd1;
      end else if (dec) begin
        pos_q <= pos_q - 32'd1;
      end
    end

    assign pos[i*32 +: 32] = pos_q;
`endif
  end

endmodule

// File: tb/tb_quad_encoder_speed.sv
// Directed self-checking bench for quad_encoder_speed: a 16-bit and a 4-bit instance share stimulus.
// Position checks are compiled in when QENC_POSITION_EN is defined.
module tb_quad_encoder_speed;

  logic        clk;
  logic        reset;
  logic [1:0]  enc_a;
  logic [1:0]  enc_b;
  logic        clear;
  logic [31:0] speed;
  logic [1:0]  dir;
  logic [1:0]  err;
  logic [1:0]  ovf;
  logic        valid;
  logic [7:0]  speed4;
  logic [1:0]  dir4;
  logic [1:0]  err4;
  logic [1:0]  ovf4;
  logic        valid4;
`ifdef QENC_POSITION_EN
  logic [63:0] pos;
  logic [63:0] pos4;
`endif

  int          total;
  int          bad;
  int          cyc;
  bit          seen_valid;
  logic [1:0]  ab [2];
  int          pos_model [2];

  quad_encoder_speed #(.N_CH(2), .CNT_W(16), .WINDOW(100), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
    .speed(speed), .dir(dir), .err(err), .ovf(ovf), .valid(valid)
`ifdef QENC_POSITION_EN
    , .pos(pos)
`endif
  );

  quad_encoder_speed #(.N_CH(2), .CNT_W(4), .WINDOW(100), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
    .speed(speed4), .dir(dir4), .err(err4), .ovf(ovf4), .valid(valid4)
`ifdef QENC_POSITION_EN
    , .pos(pos4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (valid === 1'b1) seen_valid = 1'b1;
  endtask

  function automatic logic [1:0] nextFwd(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] nextRev(input logic [1:0] s);
    case (s)
      2'b10:   return 2'b00;
      2'b11:   return 2'b10;
      2'b01:   return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic driveRaw(input int ch, input logic [1:0] val, input int hold);
    ab[ch] = val;
    enc_a[ch] = val[1];
    enc_b[ch] = val[0];
    repeat (hold) tick();
  endtask

  task automatic applyStimulus(input int ch, input bit fwd, input int n, input int hold);
    for (int k = 0; k < n; k++) begin
      pos_model[ch] += fwd ? 1 : -1;
      driveRaw(ch, fwd ? nextFwd(ab[ch]) : nextRev(ab[ch]), hold);
    end
  endtask

  task automatic waitValid(input string tag);
    int n;
    n = 0;
    while (n < 200) begin
      tick();
      n++;
      if (valid === 1'b1) break;
    end
    checkOutput({tag, "_valid"}, {31'd0, valid}, 32'd1);
    checkOutput({tag, "_valid4"}, {31'd0, valid4}, 32'd1);
    checkOutput({tag, "_period"}, cyc, 32'd100);
    cyc = 0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    seen_valid = 1'b0;
    ab[0] = 2'b00;
    ab[1] = 2'b00;
    pos_model[0] = 0;
    pos_model[1] = 0;
    enc_a = 2'b00;
    enc_b = 2'b00;
    clear = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_speed", speed, 32'd0);
    checkOutput("rst_dir", {30'd0, dir}, 32'd0);
    checkOutput("rst_err", {30'd0, err}, 32'd0);
    checkOutput("rst_ovf", {30'd0, ovf}, 32'd0);
    checkOutput("rst_valid", {31'd0, valid}, 32'd0);
    reset = 1'b0;
    cyc = 0;

    $display("[TB] window 1: 40 forward steps on ch0");
    applyStimulus(0, 1'b1, 40, 2);
    waitValid("w1");
    checkOutput("w1_speed0", {16'd0, speed[15:0]}, 32'd40);
    checkOutput("w1_speed1", {16'd0, speed[31:16]}, 32'd0);
    checkOutput("w1_dir", {30'd0, dir}, 32'b01);
    checkOutput("w1_err", {30'd0, err}, 32'd0);
    checkOutput("w1_ovf", {30'd0, ovf}, 32'd0);
    checkOutput("w1_sat4_speed", {24'd0, speed4}, 32'h07);
    checkOutput("w1_sat4_ovf", {30'd0, ovf4}, 32'b01);
    tick();
    checkOutput("w1_pulse_width", {31'd0, valid}, 32'd0);

    $display("[TB] window 2: 20 reverse steps on ch1");
    applyStimulus(1, 1'b0, 20, 2);
    waitValid("w2");
    checkOutput("w2_speed1", {16'd0, speed[31:16]}, 32'hFFEC);
    checkOutput("w2_speed0", {16'd0, speed[15:0]}, 32'd0);
    checkOutput("w2_dir", {30'd0, dir}, 32'b01);
    checkOutput("w2_ovf", {30'd0, ovf}, 32'd0);
    checkOutput("w2_sat4_speed", {24'd0, speed4}, 32'h80);
    checkOutput("w2_sat4_ovf", {30'd0, ovf4}, 32'b10);

    $display("[TB] window 3: illegal jump plus 3 forward steps on ch0");
    driveRaw(0, 2'b11, 2);
    applyStimulus(0, 1'b1, 3, 2);
    waitValid("w3");
    checkOutput("w3_speed0", {16'd0, speed[15:0]}, 32'd3);
    checkOutput("w3_err", {30'd0, err}, 32'b01);
    checkOutput("w3_err4", {30'd0, err4}, 32'b01);
    checkOutput("w3_dir", {30'd0, dir}, 32'b01);

    waitValid("w4");
    checkOutput("w4_err_clean", {30'd0, err}, 32'd0);
    checkOutput("w4_speed0", {16'd0, speed[15:0]}, 32'd0);

    $display("[TB] window 5: 10 forward steps, 4-bit instance saturates");
    applyStimulus(0, 1'b1, 10, 2);
    waitValid("w5");
    checkOutput("w5_speed0", {16'd0, speed[15:0]}, 32'd10);
    checkOutput("w5_ovf", {30'd0, ovf}, 32'd0);
    checkOutput("w5_sat4_speed", {28'd0, speed4[3:0]}, 32'd7);
    checkOutput("w5_sat4_ovf", {30'd0, ovf4}, 32'b01);

    applyStimulus(0, 1'b1, 6, 2);
    waitValid("w6");
    checkOutput("w6_speed0", {16'd0, speed[15:0]}, 32'd6);
    checkOutput("w6_sat4_speed", {28'd0, speed4[3:0]}, 32'd6);
    checkOutput("w6_sat4_ovf_clean", {30'd0, ovf4}, 32'd0);

    $display("[TB] clear coincident with window end");
    applyStimulus(0, 1'b1, 8, 2);
    while (cyc < 99) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("clr_no_valid", {31'd0, valid}, 32'd0);
    cyc = 0;
    seen_valid = 1'b0;
    applyStimulus(0, 1'b1, 2, 2);
    while (cyc < 99) tick();
    checkOutput("clr_quiet", {31'd0, seen_valid}, 32'd0);
    checkOutput("clr_speed_hold", {16'd0, speed[15:0]}, 32'd6);
    tick();
    checkOutput("clr_next_valid", {31'd0, valid}, 32'd1);
    checkOutput("clr_speed_new", {16'd0, speed[15:0]}, 32'd2);

`ifdef QENC_POSITION_EN
    checkOutput("pos0", pos[31:0], 32'(pos_model[0]));
    checkOutput("pos1", pos[63:32], 32'(pos_model[1]));
`endif

    $display("[TB] reset mid-window");
    applyStimulus(0, 1'b1, 3, 2);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst2_speed", speed, 32'd0);
    checkOutput("rst2_dir", {30'd0, dir}, 32'd0);
    checkOutput("rst2_valid", {31'd0, valid}, 32'd0);
`ifdef QENC_POSITION_EN
    checkOutput("rst2_pos", pos[31:0], 32'd0);
`endif
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
